// File: rtl/d16_dram_if.sv
// d16_dram_if: level-held request / one-cycle completion bus to the external DRAM controller
interface d16_dram_if;
   logic [31:0] dram_data_in;
   logic        dram_data_valid;
   logic        dram_write_complete;
   logic [31:0] dram_data_out;
   logic [23:0] dram_addr;
   logic        dram_req_read;
   logic        dram_req_write;
   modport master(input dram_data_in, dram_data_valid, dram_write_complete,
                  output dram_data_out, dram_addr, dram_req_read, dram_req_write);
   modport slave(output dram_data_in, dram_data_valid, dram_write_complete,
                 input dram_data_out, dram_addr, dram_req_read, dram_req_write);
endinterface

// File: rtl/d16_core.sv
// d16_core: DRAM boot self-test, then UART-to-DRAM store/echo engine with LEDs and switch tone
module d16_core #(
   parameter int CLKS_PER_BIT = 434,
   parameter int SND_DIV      = 1024
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   input  logic [3:0] switches,
   output logic [7:0] LED,
   output logic       tx,
   output logic       snd_out,
   output logic [3:0] snd_signals,
   d16_dram_if.master bus
);
   localparam logic [2:0] S_BW = 3'd0, S_BR = 3'd1, S_IDLE = 3'd2, S_WR = 3'd3, S_RD = 3'd4, S_TX = 3'd5;
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BL = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BH = BW'(CLKS_PER_BIT / 2 - 1);
   localparam int SW = $clog2(SND_DIV * 15 + 1);
   logic [2:0]    st;
   logic [23:0]   wp;
   logic [7:0]    b;
   logic [9:0]    tx_sh;
   logic [BW-1:0] tx_cnt, rx_cnt;
   logic [3:0]    tx_bit, rx_bit;
   logic          s1, s2, s3, rx_act, full;
   logic [7:0]    rx_sh, rx_buf;
   logic [SW-1:0] snd_cnt, lim;
   assign tx  = tx_sh[0];
   assign lim = SW'(SND_DIV) * SW'(snd_signals);
   always_ff @(posedge clk) begin
      if (rst_n) begin
         st                 <= S_BW;
         bus.dram_req_write <= 1'b0;
         bus.dram_req_read  <= 1'b0;
         bus.dram_addr      <= 24'd0;
         bus.dram_data_out  <= 32'd0;
         LED                <= 8'd0;
         wp                 <= 24'h000001;
         b                  <= 8'd0;
         tx_sh              <= '1;
         tx_cnt             <= '0;
         tx_bit             <= 4'd0;
      end else begin
         // requests issue from a dropped request, so one idle cycle always separates them
         if (st == S_BW || st == S_WR) begin
            if (!bus.dram_req_write) begin
               bus.dram_req_write <= 1'b1;
               bus.dram_addr      <= st == S_WR ? wp : 24'd0;
               bus.dram_data_out  <= st == S_WR ? {24'h0, b} : 32'd0;
            end else if (bus.dram_write_complete) begin
               bus.dram_req_write <= 1'b0;
               st                 <= st == S_WR ? S_RD : S_BR;
            end
         end
         if (st == S_BR || st == S_RD) begin
            if (!bus.dram_req_read) begin
               bus.dram_req_read <= 1'b1;
               bus.dram_addr     <= st == S_RD ? wp : 24'd0;
            end else if (bus.dram_data_valid) begin
               bus.dram_req_read <= 1'b0;
               LED               <= bus.dram_data_in[7:0];
               st                <= st == S_RD ? S_TX : S_IDLE;
               if (st == S_RD) begin
                  wp     <= wp + 24'd1;
                  tx_sh  <= {1'b1, bus.dram_data_in[7:0], 1'b0};
                  tx_cnt <= '0;
                  tx_bit <= 4'd0;
               end
            end
         end
         if (st == S_IDLE && full) begin
            b  <= rx_buf;
            st <= S_WR;
         end
         if (st == S_TX) begin
            if (tx_cnt == BL) begin
               tx_cnt <= '0;
               tx_sh  <= {1'b1, tx_sh[9:1]};
               tx_bit <= tx_bit + 4'd1;
               if (tx_bit == 4'd9) st <= S_IDLE;
            end else tx_cnt <= tx_cnt + BW'(1);
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst_n) begin
         {s3, s2, s1} <= 3'b111;
         rx_act       <= 1'b0;
         rx_cnt       <= '0;
         rx_bit       <= 4'd0;
         rx_sh        <= 8'd0;
         rx_buf       <= 8'd0;
         full         <= 1'b0;
      end else begin
         {s3, s2, s1} <= {s2, s1, rx};
         if (st == S_IDLE && full) full <= 1'b0;
         if (!rx_act) begin
            if (s3 && !s2) begin
               rx_act <= 1'b1;
               rx_cnt <= '0;
               rx_bit <= 4'd0;
            end
         end else if (rx_cnt != (rx_bit == 4'd0 ? BH : BL)) rx_cnt <= rx_cnt + BW'(1);
         else begin
            rx_cnt <= '0;
            rx_bit <= rx_bit + 4'd1;
            if (rx_bit == 4'd0 && s2) rx_act <= 1'b0;
            else if (rx_bit == 4'd9) begin
               rx_act <= 1'b0;
               // a byte arriving while the buffer is still full is dropped
               if (s2 && !full) begin
                  rx_buf <= rx_sh;
                  full   <= 1'b1;
               end
            end else if (rx_bit != 4'd0) rx_sh <= {s2, rx_sh[7:1]};
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst_n) begin
         snd_signals <= 4'd0;
         snd_out     <= 1'b0;
         snd_cnt     <= '0;
      end else begin
         snd_signals <= switches;
         if (snd_signals == 4'd0) begin
            snd_out <= 1'b0;
            snd_cnt <= '0;
         end else if (switches != snd_signals) snd_cnt <= '0;
         else if (snd_cnt == lim - SW'(1)) begin
            snd_cnt <= '0;
            snd_out <= ~snd_out;
         end else snd_cnt <= snd_cnt + SW'(1);
      end
   end
endmodule

// File: tb/tb_d16_core.sv
// tb_d16_core: directed checks of boot self-test, UART store/echo, overrun, framing, tone and reset
module tb_d16_core;
   logic clk = 0, rst_n = 1, rx = 1;
   logic [3:0] switches = 4'd5;
   logic [7:0] LED;
   logic tx, snd_out;
   logic [3:0] snd_signals;
   d16_dram_if bus();
   d16_core #(.CLKS_PER_BIT(16), .SND_DIV(8)) dut (
      .clk(clk), .rst_n(rst_n), .rx(rx), .switches(switches), .LED(LED), .tx(tx),
      .snd_out(snd_out), .snd_signals(snd_signals), .bus(bus));
   always #5 clk = ~clk;
   int errors = 0, checks = 0;
   logic junk = 1, mode = 0, ph = 0;
   int wdly = 4, rdly = 8, wcnt = 0, rcnt = 0, nwr = 0, nrd = 0, both_hi = 0;
   logic [23:0] wa [32];
   logic [23:0] ra [32];
   logic [31:0] wd [32];
   logic [31:0] mem = 0;
   // DRAM model; while junk is set it sprays completion pulses regardless of requests
   always @(posedge clk) begin
      if (bus.dram_req_read && bus.dram_req_write) both_hi <= both_hi + 1;
      if (junk) begin
         ph <= ~ph;
         bus.dram_write_complete <= ph;
         bus.dram_data_valid <= ~ph;
         bus.dram_data_in <= 32'hdeadbeef;
         wcnt <= 0;
         rcnt <= 0;
      end else begin
         bus.dram_write_complete <= 1'b0;
         bus.dram_data_valid <= 1'b0;
         if (bus.dram_req_write && !bus.dram_write_complete) begin
            if (wcnt == wdly - 1) begin
               bus.dram_write_complete <= 1'b1;
               wcnt <= 0;
               mem <= bus.dram_data_out;
               wa[nwr % 32] <= bus.dram_addr;
               wd[nwr % 32] <= bus.dram_data_out;
               nwr <= nwr + 1;
            end else wcnt <= wcnt + 1;
         end else wcnt <= 0;
         if (bus.dram_req_read && !bus.dram_data_valid) begin
            if (rcnt == rdly - 1) begin
               bus.dram_data_valid <= 1'b1;
               bus.dram_data_in <= mode ? mem : 32'hdeadbeef;
               rcnt <= 0;
               ra[nrd % 32] <= bus.dram_addr;
               nrd <= nrd + 1;
            end else rcnt <= rcnt + 1;
         end else rcnt <= 0;
      end
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic send(input logic [7:0] d, input logic stop);
      @(negedge clk); rx = 0; repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) begin rx = d[i]; repeat (16) @(negedge clk); end
      rx = stop; repeat (16) @(negedge clk); rx = 1;
   endtask
   task automatic recv(output logic [7:0] d, output logic ok);
      ok = 0; d = 0;
      for (int i = 0; i < 2000 && tx !== 1'b0; i++) @(negedge clk);
      if (tx !== 1'b0) return;
      repeat (8) @(negedge clk);
      if (tx !== 1'b0) return;
      for (int k = 0; k < 8; k++) begin repeat (16) @(negedge clk); d[k] = tx; end
      repeat (16) @(negedge clk);
      ok = (tx === 1'b1);
   endtask
   task automatic wait_req(input logic rd, input int n, output logic seen);
      seen = 0;
      for (int i = 0; i < n && !seen; i++) begin
         @(negedge clk);
         seen = (rd ? bus.dram_req_read : bus.dram_req_write) === 1'b1;
      end
   endtask
   task automatic boot(input string t);
      logic s;
      wait_req(0, 3, s);
      chk({t, "_wreq"}, s, 1);
      chk({t, "_waddr"}, bus.dram_addr, 0);
      chk({t, "_wdata"}, bus.dram_data_out, 0);
      wait_req(1, 20, s);
      chk({t, "_rreq"}, s, 1);
      chk({t, "_raddr"}, bus.dram_addr, 0);
      for (int i = 0; i < 20 && LED !== 8'hEF; i++) @(negedge clk);
      chk({t, "_led"}, LED, 8'hEF);
   endtask
   task automatic echo(input string t, input logic [7:0] d, input logic [7:0] exp, input logic [23:0] a);
      int nw, nr;
      logic [7:0] got;
      logic ok;
      nw = nwr; nr = nrd;
      send(d, 1);
      recv(got, ok);
      chk({t, "_tx_frame"}, ok, 1);
      chk({t, "_tx_byte"}, got, exp);
      chk({t, "_led"}, LED, exp);
      chk({t, "_nwr"}, nwr, nw + 1);
      chk({t, "_waddr"}, wa[nw % 32], a);
      chk({t, "_wdata"}, wd[nw % 32], {24'h0, d});
      chk({t, "_raddr"}, ra[nr % 32], a);
   endtask
   initial begin
      int nw, c;
      logic v, s, ok;
      logic [7:0] got;
      repeat (2) @(negedge clk);
      chk("rst_led", LED, 0);
      chk("rst_tx", tx, 1);
      chk("rst_snd", snd_out, 0);
      chk("rst_snd_sig", snd_signals, 0);
      chk("rst_data", bus.dram_data_out, 0);
      chk("rst_addr", bus.dram_addr, 0);
      chk("rst_req", {bus.dram_req_read, bus.dram_req_write}, 0);
      rst_n = 0; junk = 0; switches = 0;
      boot("boot");
      nw = nwr; c = nrd;
      repeat (50) @(negedge clk);
      chk("idle_nwr", nwr, nw);
      chk("idle_nrd", nrd, c);
      chk("idle_req", {bus.dram_req_read, bus.dram_req_write}, 0);
      mode = 1;
      echo("b41", 8'h41, 8'h41, 24'd1);
      echo("b5a", 8'h5A, 8'h5A, 24'd2);
      mode = 0;
      echo("fixed", 8'h33, 8'hEF, 24'd3);
      nw = nwr;
      send(8'hA5, 0);
      repeat (100) @(negedge clk);
      chk("frame_nwr", nwr, nw);
      chk("frame_led", LED, 8'hEF);
      chk("frame_req", {bus.dram_req_read, bus.dram_req_write}, 0);
      switches = 4'd2;
      @(posedge clk); #1;
      chk("snd_sig", snd_signals, 2);
      v = snd_out; c = 0;
      while (snd_out === v && c < 40) begin @(negedge clk); c++; end
      v = snd_out; c = 0;
      while (snd_out === v && c < 40) begin @(negedge clk); c++; end
      chk("snd_period", c, 16);
      switches = 4'd0;
      repeat (2) @(negedge clk);
      chk("snd_off", snd_out, 0);
      chk("snd_sig_off", snd_signals, 0);
      mode = 1; wdly = 200; rdly = 200; nw = nwr;
      send(8'h11, 1); send(8'h22, 1); send(8'h33, 1);
      recv(got, ok);
      chk("ovr_first", {ok, got}, {1'b1, 8'h11});
      recv(got, ok);
      chk("ovr_second", {ok, got}, {1'b1, 8'h22});
      repeat (700) @(negedge clk);
      chk("ovr_nwr", nwr, nw + 2);
      chk("ovr_a0", {wa[nw % 32], wd[nw % 32]}, {24'd4, 32'h11});
      chk("ovr_a1", {wa[(nw + 1) % 32], wd[(nw + 1) % 32]}, {24'd5, 32'h22});
      chk("ovr_led", LED, 8'h22);
      send(8'h77, 1);
      wait_req(0, 40, s);
      chk("mid_wreq", s, 1);
      @(negedge clk); rst_n = 1; junk = 1;
      @(posedge clk); #1;
      chk("mid_req_drop", {bus.dram_req_read, bus.dram_req_write}, 0);
      repeat (3) @(negedge clk);
      chk("mid_led", LED, 0);
      chk("mid_tx", tx, 1);
      chk("mid_req_hold", {bus.dram_req_read, bus.dram_req_write}, 0);
      wdly = 4; rdly = 8; mode = 0; rst_n = 0; junk = 0;
      boot("reboot");
      mode = 1;
      echo("wp_reset", 8'h99, 8'h99, 24'd1);
      chk("one_request", both_hi, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
